mmio_bus_ctrl: RTL and testbench
================================

# mmio_bus_ctrl

Sequencer between the CPU memory stage and the MMIO peripherals (LEDs, switches, segment display, …) in the 0xFFFF0000 region. It latches one CPU MMIO access and broadcasts it to all peripherals. It identifies the single claiming peripheral from the `dev_work` vector and drives the request until that peripheral's one-cycle `mmio_done` pulse. It then returns the read data and a completion or error pulse to the CPU, and stalls the CPU while the access is in flight.

## Interface
Parameters:
- `N_DEV`, 4, number of attached peripherals (1–16).
- `TIMEOUT`, 15, maximum cycles in `REQ` before a bus error (≥2).

Ports:
- `sys_clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_read`  in  1  MMIO load request, sampled in `IDLE`.
- `cpu_write`  in  1  MMIO store request, sampled in `IDLE`.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data.
- `cpu_stall`  out  1  hold the pipeline.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  qualifies `cpu_done` as a bus error.
- `cpu_rdata`  out  32  load data, valid with `cpu_done`.
- `dev_read`  out  1  broadcast read strobe.
- `dev_write`  out  1  broadcast write strobe.
- `dev_addr`  out  32  broadcast address (latched).
- `dev_wdata`  out  32  broadcast write data (latched).
- `dev_work`  in  N_DEV  per-device address claim.
- `dev_done`  in  N_DEV  per-device done pulse.
- `dev_rdata`  in  32*N_DEV  per-device read data; device i occupies bits [32i+31:32i].

## Operation
- FSM states: `IDLE`, `REQ`, `RESP`, `ERR`.
- **IDLE**
  - All `dev_*` strobes are 0.
  - On `cpu_read ^ cpu_write`: latch op, addr and wdata, clear the timeout counter, go to `REQ`.
  - On `cpu_read & cpu_write`: go to `ERR`; nothing is broadcast.
- **REQ**
  - Drive `dev_read` or `dev_write` from the latched op, and drive `dev_addr`/`dev_wdata` from the latches.
  - Claim check on every cycle in `REQ`:
    - `dev_work` == 0 → `ERR`.
    - More than one bit set → `ERR`.
    - Exactly one bit set (index k): wait for `dev_done[k]`. On that edge, capture `dev_rdata[k]` (reads only; writes capture 0) and go to `RESP`.
  - `dev_done` from non-claiming devices is ignored.
- **RESP**
  - `cpu_done`=1 and `cpu_rdata`=captured data for exactly one cycle.
  - `dev_read`/`dev_write`=0 in this cycle, so peripherals see the strobe drop immediately after their done pulse and never execute a second write.
  - Next state is `IDLE`.
- **ERR**
  - `cpu_done`=1, `cpu_err`=1, `cpu_rdata`=0 for one cycle; strobes are 0.
  - Next state is `IDLE`.
- `cpu_stall` (combinational) = (`IDLE` & (`cpu_read` | `cpu_write`)) | `REQ`. It is 0 in `RESP` and `ERR`.
- CPU request inputs are ignored outside `IDLE`.
- `dev_addr` and `dev_wdata` hold their latched values until the next accept.
- Reset (asynchronous, any state, including mid-`REQ`):
  - State goes to `IDLE`.
  - All outputs go to 0: `cpu_*`, `dev_read`, `dev_write`, `dev_addr`, `dev_wdata`, captured data, timeout counter.
  - Any in-flight access is abandoned with no completion pulse.

## Timing
- Accept edge T0 (`IDLE` → `REQ`).
  - Strobes are visible during cycle T0+1.
  - A peripheral with a registered done asserts `dev_done` in cycle T0+2.
  - `cpu_done` is high in cycle T0+3.
  - Minimum access is 3 cycles.
- The earliest next accept is the cycle after `cpu_done`, because the FSM passes through `IDLE`.
- Timeout counter:
  - Increments on every `REQ` cycle; the width is $clog2(TIMEOUT+1).
  - `ERR` is entered when the count reaches `TIMEOUT` with no `dev_done[k]`.
  - If `dev_done[k]` arrives on the same edge as the timeout, done wins and the FSM goes to `RESP`.
- Claim changes mid-`REQ` cannot occur for a stable address; if one does, the claim check on that cycle governs.

## Configuration
- `MMIO_BUS_TIMEOUT_EN` defined: the timeout counter and the `REQ`→`ERR` timeout path are compiled in.
- Undefined: no counter exists; `REQ` waits indefinitely for `dev_done[k]`. The no-claim and multi-claim errors remain.

## Structure
- Shared package `mmio_pkg`:
  - FSM state typedef (2-bit enum).
  - `MMIO_BASE` (32'hFFFF0000) and the per-peripheral region constants (LEDs 0xFFFF0080–0xFFFF00FF, …).
  - `MMIO_DW`=32.
- One sub-module `mmio_claim_decode`: combinational `dev_work` → `one`, `none`, `multi` and `idx[$clog2(N_DEV)-1:0]`. This keeps the FSM body free of the one-hot checks.

## Test plan
- Write 32'h1 to 0xFFFF0084 with LED model at device 1:
  - `dev_write` is high for exactly 2 cycles.
  - `cpu_done` is high at T0+3 with `cpu_err`=0.
  - LED bit 1 = 1.
  - The model sees a single write.
- Read 0xFFFF0084 after that write:
  - `cpu_rdata`=32'h1 at T0+3.
  - `cpu_stall` is high for cycles T0 to T0+2.
- Access to unmapped 0xFFFF1000 (`dev_work`=0) → `cpu_done` & `cpu_err` at T0+2, `cpu_rdata`=0.
- Two devices claim 0xFFFF0080 → `ERR`, `cpu_err`=1.
- Device that never asserts done, `TIMEOUT`=15:
  - With `MMIO_BUS_TIMEOUT_EN`: `cpu_err` pulse after 15 `REQ` cycles.
  - Without it: stall persists for 100+ cycles.
- `rst` asserted mid-`REQ`: all outputs 0 asynchronously, state `IDLE`, no `cpu_done`. A following read then completes normally in 3 cycles.

Source files
------------

// File: rtl/mmio_pkg.sv
// ============================================================================
// Module  : mmio_pkg
// Brief   : Shared types and address map for the MMIO bus sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

    localparam int MMIO_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } mmio_state_e;

    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
    localparam logic [31:0] LED_BASE  = 32'hFFFF_0080;
    localparam logic [31:0] LED_LAST  = 32'hFFFF_00FF;
    localparam logic [31:0] SW_BASE   = 32'hFFFF_0100;
    localparam logic [31:0] SW_LAST   = 32'hFFFF_017F;
    localparam logic [31:0] SEG_BASE  = 32'hFFFF_0180;
    localparam logic [31:0] SEG_LAST  = 32'hFFFF_01FF;

    // Inclusive window test used by peripherals to form their dev_work claim.
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_claim_decode.sv
// ============================================================================
// Module  : mmio_claim_decode
// Brief   : Classifies the dev_work claim vector as none / one / multi and
//           returns the index of the claiming device.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_claim_decode #(
    parameter int N_DEV = 4,
    parameter int IW    = 2
) (
    input  logic [N_DEV-1:0] dev_work,
    output logic             one,
    output logic             none,
    output logic             multi,
    output logic [IW-1:0]    idx
);

    logic [4:0] count;

    // idx is only meaningful when exactly one bit is set.
    always_comb begin
        count = '0;
        idx   = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (dev_work[i]) begin
                count = count + 5'd1;
                idx   = IW'(i);
            end
        end
    end

    assign none  = (count == 5'd0);
    assign one   = (count == 5'd1);
    assign multi = (count >  5'd1);

endmodule

`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
// ============================================================================
// Module  : mmio_bus_ctrl
// Brief   : Latches one CPU MMIO access, broadcasts it to the peripherals and
//           returns data / completion / bus error. Optional request timeout is
//           compiled in with `define MMIO_BUS_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int N_DEV   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     cpu_read,
    input  logic                     cpu_write,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    output logic                     cpu_stall,
    output logic                     cpu_done,
    output logic                     cpu_err,
    output logic [MMIO_DW-1:0]       cpu_rdata,
    output logic                     dev_read,
    output logic                     dev_write,
    output logic [31:0]              dev_addr,
    output logic [MMIO_DW-1:0]       dev_wdata,
    input  logic [N_DEV-1:0]         dev_work,
    input  logic [N_DEV-1:0]         dev_done,
    input  logic [MMIO_DW*N_DEV-1:0] dev_rdata
);

    localparam int IW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    if ((N_DEV < 1) || (N_DEV > 16) || (TIMEOUT < 2)) begin : g_param_check
        $error("mmio_bus_ctrl: N_DEV must be 1..16 and TIMEOUT >= 2");
    end

    mmio_state_e          state;
    logic                 claim_one;
    logic                 claim_none;
    logic                 claim_multi;
    logic [IW-1:0]        claim_idx;
    logic                 sel_done;
    logic [MMIO_DW-1:0]   sel_rdata;
    logic                 to_hit;

    mmio_claim_decode #(
        .N_DEV (N_DEV),
        .IW    (IW)
    ) u_claim (
        .dev_work (dev_work),
        .one      (claim_one),
        .none     (claim_none),
        .multi    (claim_multi),
        .idx      (claim_idx)
    );

    assign sel_done  = dev_done[claim_idx];
    assign sel_rdata = dev_rdata[int'(claim_idx)*MMIO_DW +: MMIO_DW];

`ifdef MMIO_BUS_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] to_cnt;

    // Counter holds the number of REQ cycles already elapsed; the last one
    // is flagged so the edge leaving it lands in ERR after TIMEOUT cycles.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == ST_REQ) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign to_hit = (to_cnt == TO_LAST);
`else
    assign to_hit = 1'b0;
`endif

    assign cpu_stall = ((state == ST_IDLE) && (cpu_read || cpu_write)) ||
                       (state == ST_REQ);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            dev_read  <= 1'b0;
            dev_write <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
        end else begin
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    dev_read  <= 1'b0;
                    dev_write <= 1'b0;
                    if (cpu_read && cpu_write) begin
                        state    <= ST_ERR;
                        cpu_done <= 1'b1;
                        cpu_err  <= 1'b1;
                    end else if (cpu_read || cpu_write) begin
                        state     <= ST_REQ;
                        dev_read  <= cpu_read;
                        dev_write <= cpu_write;
                        dev_addr  <= cpu_addr;
                        dev_wdata <= cpu_wdata;
                    end
                end
                ST_REQ: begin
                    // Claim problems win over everything; done wins over timeout.
                    if (claim_none || claim_multi) begin
                        state     <= ST_ERR;
                        dev_read  <= 1'b0;
                        dev_write <= 1'b0;
                        cpu_done  <= 1'b1;
                        cpu_err   <= 1'b1;
                    end else if (claim_one && sel_done) begin
                        state     <= ST_RESP;
                        dev_read  <= 1'b0;
                        dev_write <= 1'b0;
                        cpu_done  <= 1'b1;
                        cpu_rdata <= dev_write ? '0 : sel_rdata;
                    end else if (to_hit) begin
                        state     <= ST_ERR;
                        dev_read  <= 1'b0;
                        dev_write <= 1'b0;
                        cpu_done  <= 1'b1;
                        cpu_err   <= 1'b1;
                    end
                end
                ST_RESP, ST_ERR: begin
                    state     <= ST_IDLE;
                    dev_read  <= 1'b0;
                    dev_write <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    dev_read  <= 1'b0;
                    dev_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
// ============================================================================
// Module  : tb_mmio_bus_ctrl
// Brief   : Directed self-checking bench for mmio_bus_ctrl with LED, switch,
//           silent and display peripheral models.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmio_bus_ctrl;
    import mmio_pkg::*;

    logic         sys_clk = 1'b0;
    logic         rst;
    logic         dev_rst;
    logic         cpu_read, cpu_write;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic         cpu_stall, cpu_done, cpu_err;
    logic [31:0]  cpu_rdata;
    logic         dev_read, dev_write;
    logic [31:0]  dev_addr, dev_wdata;
    logic [3:0]   dev_work, dev_done;
    logic [127:0] dev_rdata;

    logic         dup_claim, force_d3;
    logic [31:0]  led_reg;
    logic         led_done, sw_done;
    int           led_writes;
    logic         strobe;

    int tests  = 0;
    int failed = 0;

    localparam logic [31:0] SW_VAL   = 32'hA5A5_0F0F;
    localparam logic [31:0] HANG_LO  = 32'hFFFF_0200;
    localparam logic [31:0] HANG_HI  = 32'hFFFF_027F;

    always #5 sys_clk = ~sys_clk;

    mmio_bus_ctrl #(.N_DEV(4), .TIMEOUT(15)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .dev_read  (dev_read),
        .dev_write (dev_write),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_work  (dev_work),
        .dev_done  (dev_done),
        .dev_rdata (dev_rdata)
    );

    // Device 0: claims a window but never completes. 1: LEDs. 2: switches.
    // 3: display, whose done can be forced to check non-claimant done is ignored.
    assign strobe      = dev_read | dev_write;
    assign dev_work[0] = in_region(dev_addr, HANG_LO, HANG_HI) |
                         (dup_claim & in_region(dev_addr, LED_BASE, LED_LAST));
    assign dev_work[1] = in_region(dev_addr, LED_BASE, LED_LAST);
    assign dev_work[2] = in_region(dev_addr, SW_BASE, SW_LAST);
    assign dev_work[3] = in_region(dev_addr, SEG_BASE, SEG_LAST);
    assign dev_done    = {force_d3, sw_done, led_done, 1'b0};
    assign dev_rdata   = {32'hDEAD_BEEF, SW_VAL, {31'b0, led_reg[dev_addr[6:2]]}, 32'hBAD0_BAD0};

    always @(posedge sys_clk or posedge dev_rst) begin
        if (dev_rst) begin
            led_reg    <= '0;
            led_done   <= 1'b0;
            led_writes <= 0;
        end else begin
            led_done <= 1'b0;
            if (dev_work[1] && strobe && !led_done) begin
                led_done <= 1'b1;
                if (dev_write) begin
                    led_reg[dev_addr[6:2]] <= dev_wdata[0];
                    led_writes <= led_writes + 1;
                end
            end
        end
    end

    always @(posedge sys_clk or posedge dev_rst) begin
        if (dev_rst) sw_done <= 1'b0;
        else         sw_done <= dev_work[2] && strobe && !sw_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    // Presents a request in an IDLE cycle (T0), returns at the T0+1 sample point.
    task automatic start(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        #1;
        chk("stall_t0", {31'b0, cpu_stall}, 32'd1);
        chk("no_strobe_t0", {30'b0, dev_read, dev_write}, 32'd0);
        @(negedge sys_clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int done_seen;
        rst = 1'b1; dev_rst = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dup_claim = 1'b0; force_d3 = 1'b0;
        step(); step();
        chk("rst_cpu", {cpu_stall, cpu_done, cpu_err, 29'b0}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_dev", {30'b0, dev_read, dev_write}, 32'd0);
        chk("rst_addr", dev_addr, 32'd0);
        chk("rst_wdata", dev_wdata, 32'd0);
        rst = 1'b0; dev_rst = 1'b0;
        step();

        // LED write
        start(1'b0, 1'b1, 32'hFFFF_0084, 32'h1);
        chk("wr_t1_write", {31'b0, dev_write}, 32'd1);
        chk("wr_t1_addr", dev_addr, 32'hFFFF_0084);
        chk("wr_t1_wdata", dev_wdata, 32'h1);
        chk("wr_t1_stall", {31'b0, cpu_stall}, 32'd1);
        step();
        chk("wr_t2_write", {31'b0, dev_write}, 32'd1);
        chk("wr_t2_done", {31'b0, cpu_done}, 32'd0);
        step();
        chk("wr_t3_done", {31'b0, cpu_done}, 32'd1);
        chk("wr_t3_err", {31'b0, cpu_err}, 32'd0);
        chk("wr_t3_write", {31'b0, dev_write}, 32'd0);
        chk("wr_t3_stall", {31'b0, cpu_stall}, 32'd0);
        step();
        chk("wr_t4_done", {31'b0, cpu_done}, 32'd0);
        chk("led_bit1", {31'b0, led_reg[1]}, 32'd1);
        chk("led_writes", led_writes, 32'd1);
        chk("addr_hold", dev_addr, 32'hFFFF_0084);

        // LED read back
        start(1'b1, 1'b0, 32'hFFFF_0084, 32'h0);
        chk("rd_t1_read", {31'b0, dev_read}, 32'd1);
        chk("rd_t1_stall", {31'b0, cpu_stall}, 32'd1);
        step();
        chk("rd_t2_stall", {31'b0, cpu_stall}, 32'd1);
        step();
        chk("rd_t3_done", {31'b0, cpu_done}, 32'd1);
        chk("rd_t3_rdata", cpu_rdata, 32'h1);
        chk("rd_t3_stall", {31'b0, cpu_stall}, 32'd0);
        step();

        // Unmapped address
        start(1'b1, 1'b0, 32'hFFFF_1000, 32'h0);
        chk("um_t1_read", {31'b0, dev_read}, 32'd1);
        step();
        chk("um_t2_done_err", {30'b0, cpu_done, cpu_err}, 32'd3);
        chk("um_t2_rdata", cpu_rdata, 32'd0);
        chk("um_t2_read", {31'b0, dev_read}, 32'd0);
        step();

        // Two devices claim the LED window
        dup_claim = 1'b1;
        start(1'b1, 1'b0, 32'hFFFF_0080, 32'h0);
        chk("mc_t1_work", {28'b0, dev_work}, 32'h3);
        step();
        chk("mc_t2_done_err", {30'b0, cpu_done, cpu_err}, 32'd3);
        chk("mc_t2_rdata", cpu_rdata, 32'd0);
        step();
        dup_claim = 1'b0;

        // Read and write together: error without broadcast
        start(1'b1, 1'b1, 32'hFFFF_0100, 32'h5);
        chk("rw_t1_done_err", {30'b0, cpu_done, cpu_err}, 32'd3);
        chk("rw_t1_strobes", {30'b0, dev_read, dev_write}, 32'd0);
        chk("rw_t1_addr", dev_addr, 32'hFFFF_0080);
        step();

        // Switch read, with a CPU request that must be ignored mid-access
        start(1'b1, 1'b0, 32'hFFFF_0100, 32'h0);
        cpu_write = 1'b1; cpu_addr = 32'hFFFF_0084;
        step();
        cpu_write = 1'b0;
        chk("sw_t2_addr", dev_addr, 32'hFFFF_0100);
        chk("sw_t2_strobes", {30'b0, dev_read, dev_write}, 32'd2);
        step();
        chk("sw_t3_done", {31'b0, cpu_done}, 32'd1);
        chk("sw_t3_rdata", cpu_rdata, SW_VAL);
        step();

        // Switch write returns zero data
        start(1'b0, 1'b1, 32'hFFFF_0104, 32'h7);
        step(); step();
        chk("sww_t3_done", {30'b0, cpu_done, cpu_err}, 32'd2);
        chk("sww_t3_rdata", cpu_rdata, 32'd0);
        step();

        // Silent device; non-claimant done must not complete it
        start(1'b1, 1'b0, HANG_LO, 32'h0);
        force_d3 = 1'b1;
        step();
        force_d3 = 1'b0;
        chk("hang_t2_stall", {31'b0, cpu_stall}, 32'd1);
        chk("hang_t2_done", {31'b0, cpu_done}, 32'd0);
`ifdef MMIO_BUS_TIMEOUT_EN
        n = 2;
        while (!cpu_done && n < 40) begin
            step();
            n++;
        end
        chk("to_cycle", n, 32'd16);
        chk("to_err", {30'b0, cpu_done, cpu_err}, 32'd3);
        chk("to_rdata", cpu_rdata, 32'd0);
        step();
        start(1'b1, 1'b0, HANG_LO, 32'h0);
        step(); step();
`else
        done_seen = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (cpu_done) done_seen++;
        end
        chk("hang_no_done", done_seen, 32'd0);
        chk("hang_stall", {31'b0, cpu_stall}, 32'd1);
`endif

        // Asynchronous reset mid-REQ
        chk("pre_rst_read", {31'b0, dev_read}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_strobes", {30'b0, dev_read, dev_write}, 32'd0);
        chk("arst_addr", dev_addr, 32'd0);
        chk("arst_cpu", {29'b0, cpu_stall, cpu_done, cpu_err}, 32'd0);
        step();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cpu_done) done_seen++;
        end
        chk("arst_no_done", done_seen, 32'd0);
        start(1'b1, 1'b0, 32'hFFFF_0084, 32'h0);
        step(); step();
        chk("post_rst_done", {30'b0, cpu_done, cpu_err}, 32'd2);
        chk("post_rst_rdata", cpu_rdata, 32'h1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
